// File: rtl/pid_motor_control.sv
// Three-stage PID motor controller with deadband, anti-windup and mode select.
// An update strobe at cycle N produces a saturated duty and a duty_valid pulse at N+3.
module pid_motor_control #(
    parameter int WIDTH     = 24,
    parameter int FRAC_BITS = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             update,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] setpoint,
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] Kp,
    input  logic [WIDTH-1:0] Ki,
    input  logic [WIDTH-1:0] Kd,
    input  logic [WIDTH-1:0] PWMLimit,
    input  logic [WIDTH-1:0] IntegralLimit,
    input  logic [WIDTH-1:0] deadband,
    output logic [WIDTH-1:0] duty,
    output logic             duty_valid
);

    localparam int SW = 2 * WIDTH + 2;
    localparam int PW = 2 * WIDTH;
    typedef logic signed [SW-1:0] wide_t;

    localparam logic [1:0] MODE_PID    = 2'd1;
    localparam logic [1:0] MODE_DIRECT = 2'd2;
    localparam wide_t      MAXW = (wide_t'(1) <<< (WIDTH - 1)) - wide_t'(1);

    function automatic wide_t sx(input logic [WIDTH-1:0] v);
        return wide_t'($signed(v));
    endfunction

    // Limits are magnitudes: negative configuration values behave as zero.
    function automatic wide_t pos(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? wide_t'(0) : sx(v);
    endfunction

    function automatic wide_t sat(input wide_t v, input wide_t lim);
        if (v > lim) return lim;
        else if (v < -lim) return -lim;
        else return v;
    endfunction

    logic [WIDTH-1:0] integral, err_prev;
    logic [WIDTH-1:0] raw_n, err_n, int_n, deriv_n;

    logic             s1_valid, s2_valid;
    logic [1:0]       s1_mode, s2_mode;
    logic [WIDTH-1:0] s1_err, s1_int, s1_deriv;
    logic [WIDTH-1:0] s1_kp, s1_ki, s1_kd;
    logic [WIDTH-1:0] s1_pl, s2_pl, s1_sp, s2_sp;
    logic signed [PW-1:0] s2_p, s2_i, s2_d;
    logic [WIDTH-1:0] duty_n;

    always_comb begin
        raw_n   = WIDTH'(sat(sx(setpoint) - sx(state), MAXW));
        err_n   = raw_n;
        if ((raw_n[WIDTH-1] ? -sx(raw_n) : sx(raw_n)) <= pos(deadband))
            err_n = '0;
        int_n   = WIDTH'(sat(sx(integral) + sx(err_n), pos(IntegralLimit)));
        deriv_n = WIDTH'(sat(sx(err_n) - sx(err_prev), MAXW));
    end

    always_comb begin
        duty_n = '0;
        unique case (s2_mode)
            MODE_PID: begin
                duty_n = WIDTH'(sat((wide_t'(s2_p) + wide_t'(s2_i) + wide_t'(s2_d))
                                    >>> FRAC_BITS, pos(s2_pl)));
            end
            MODE_DIRECT: duty_n = WIDTH'(sat(sx(s2_sp), pos(s2_pl)));
            default:     duty_n = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            integral   <= '0;
            err_prev   <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            duty       <= '0;
            duty_valid <= 1'b0;
        end else begin
            s1_valid   <= update;
            s2_valid   <= s1_valid;
            duty_valid <= s2_valid;
            if (update) begin
                // err_prev tracks in every mode so entering PID gives no kick.
                err_prev <= err_n;
                integral <= (mode == MODE_PID) ? int_n : '0;
                s1_mode  <= mode;
                s1_err   <= err_n;
                s1_int   <= int_n;
                s1_deriv <= deriv_n;
                s1_kp    <= Kp;
                s1_ki    <= Ki;
                s1_kd    <= Kd;
                s1_pl    <= PWMLimit;
                s1_sp    <= setpoint;
            end
            if (s1_valid) begin
                s2_mode <= s1_mode;
                s2_pl   <= s1_pl;
                s2_sp   <= s1_sp;
                s2_p    <= PW'($signed(s1_kp)) * PW'($signed(s1_err));
                s2_i    <= PW'($signed(s1_ki)) * PW'($signed(s1_int));
                s2_d    <= PW'($signed(s1_kd)) * PW'($signed(s1_deriv));
            end
            if (s2_valid)
                duty <= duty_n;
        end
    end

endmodule

// File: tb/tb_pid_motor_control.sv
// Directed bench for pid_motor_control: latency, clamps, integral, derivative,
// deadband, modes, back-to-back updates and reset flushing.
module tb_pid_motor_control;

    logic        CLK = 1'b0;
    logic        reset, update;
    logic [1:0]  mode;
    logic [23:0] setpoint, state, Kp, Ki, Kd;
    logic [23:0] PWMLimit, IntegralLimit, deadband;
    logic [23:0] duty;
    logic        duty_valid;

    int tests = 0;
    int fails = 0;

    pid_motor_control #(.WIDTH(24), .FRAC_BITS(8)) dut (
        .CLK(CLK), .reset(reset), .update(update), .mode(mode),
        .setpoint(setpoint), .state(state), .Kp(Kp), .Ki(Ki), .Kd(Kd),
        .PWMLimit(PWMLimit), .IntegralLimit(IntegralLimit),
        .deadband(deadband), .duty(duty), .duty_valid(duty_valid)
    );

    always #5 CLK = ~CLK;

    task automatic defaults();
        mode = 2'd1; setpoint = '0; state = '0;
        Kp = '0; Ki = '0; Kd = '0;
        PWMLimit = 24'd5000; IntegralLimit = 24'd250; deadband = '0;
    endtask

    // One update; lat_ok is set when duty_valid is low for two cycles then high.
    task automatic run1(input int sp, input logic [1:0] m,
                        output logic [23:0] d, output logic lat_ok);
        logic early;
        setpoint = 24'(sp); state = '0; mode = m; update = 1'b1;
        @(posedge CLK); #1;
        update = 1'b0;
        early = duty_valid;
        @(posedge CLK); #1;
        early = early | duty_valid;
        @(posedge CLK); #1;
        lat_ok = !early && duty_valid;
        d = duty;
    endtask

    task automatic test_reset();
        logic seen;
        defaults();
        reset = 1'b1; update = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        tests++;
        if (duty !== 24'd0 || duty_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_state duty=%0d dv=%0b want 0/0", $signed(duty), duty_valid);
        end
        Kp = 24'd256; setpoint = 24'd1000; update = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0; update = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
            seen = seen | duty_valid;
        end
        tests++;
        if (seen !== 1'b0 || duty !== 24'd0) begin
            fails++;
            $display("FAIL reset_with_update dv_seen=%0b duty=%0d want 0/0", seen, $signed(duty));
        end
    endtask

    task automatic test_p_path();
        logic [23:0] d, e;
        logic ok;
        int sps[3] = '{1000, 1000, -1000};
        int kps[3] = '{256, 2560, 2560};
        int exp[3] = '{1000, 5000, -5000};
        defaults();
        for (int i = 0; i < 3; i++) begin
            Kp = 24'(kps[i]);
            run1(sps[i], 2'd1, d, ok);
            e = 24'(exp[i]);
            tests++;
            if (!ok || d !== e) begin
                fails++;
                $display("FAIL p_path[%0d] duty=%0d lat_ok=%0b want %0d", i, $signed(d), ok, exp[i]);
            end
        end
        setpoint = 24'd77; Kp = 24'd999;
        repeat (4) @(posedge CLK);
        #1;
        e = 24'(-5000);
        tests++;
        if (duty !== e || duty_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold duty=%0d dv=%0b want -5000/0", $signed(duty), duty_valid);
        end
    endtask

    task automatic test_integral();
        logic [23:0] d, e;
        logic ok;
        int exp[5] = '{100, 200, 250, 250, 150};
        defaults();
        run1(0, 2'd0, d, ok);
        Ki = 24'd256;
        for (int i = 0; i < 5; i++) begin
            run1((i == 4) ? -100 : 100, 2'd1, d, ok);
            e = 24'(exp[i]);
            tests++;
            if (!ok || d !== e) begin
                fails++;
                $display("FAIL integral[%0d] duty=%0d lat_ok=%0b want %0d", i, $signed(d), ok, exp[i]);
            end
        end
    endtask

    task automatic test_derivative();
        logic [23:0] d, e;
        logic ok;
        int sps[5]   = '{0, 100, 100, 100, 100};
        int modes[5] = '{1, 1, 1, 0, 1};
        int exp[5]   = '{0, 100, 0, 0, 0};
        defaults();
        run1(0, 2'd0, d, ok);
        Kd = 24'd256;
        for (int i = 0; i < 5; i++) begin
            run1(sps[i], 2'(modes[i]), d, ok);
            e = 24'(exp[i]);
            tests++;
            if (!ok || d !== e) begin
                fails++;
                $display("FAIL deriv[%0d] duty=%0d lat_ok=%0b want %0d", i, $signed(d), ok, exp[i]);
            end
        end
    endtask

    task automatic test_deadband();
        logic [23:0] d, e;
        logic ok;
        int sps[3] = '{40, -50, 60};
        int exp[3] = '{0, 0, 120};
        defaults();
        run1(0, 2'd0, d, ok);
        deadband = 24'd50; Kp = 24'd256; Ki = 24'd256;
        for (int i = 0; i < 3; i++) begin
            run1(sps[i], 2'd1, d, ok);
            e = 24'(exp[i]);
            tests++;
            if (!ok || d !== e) begin
                fails++;
                $display("FAIL deadband[%0d] duty=%0d lat_ok=%0b want %0d", i, $signed(d), ok, exp[i]);
            end
        end
    endtask

    task automatic test_modes();
        logic [23:0] d, e;
        logic ok;
        defaults();
        Ki = 24'd256;
        run1(200, 2'd1, d, ok);
        run1(-7000, 2'd2, d, ok);
        e = 24'(-5000);
        tests++;
        if (!ok || d !== e) begin
            fails++;
            $display("FAIL direct duty=%0d lat_ok=%0b want -5000", $signed(d), ok);
        end
        run1(300, 2'd3, d, ok);
        tests++;
        if (!ok || d !== 24'd0) begin
            fails++;
            $display("FAIL off duty=%0d lat_ok=%0b want 0", $signed(d), ok);
        end
        run1(10, 2'd1, d, ok);
        tests++;
        if (!ok || d !== 24'd10) begin
            fails++;
            $display("FAIL int_cleared duty=%0d lat_ok=%0b want 10", $signed(d), ok);
        end
    endtask

    task automatic test_limits();
        logic [23:0] d, e;
        logic ok;
        defaults();
        Kp = 24'd256; PWMLimit = 24'd0;
        run1(1000, 2'd1, d, ok);
        tests++;
        if (!ok || d !== 24'd0) begin
            fails++;
            $display("FAIL pwm_zero duty=%0d want 0", $signed(d));
        end
        PWMLimit = 24'(-10);
        run1(1000, 2'd1, d, ok);
        tests++;
        if (!ok || d !== 24'd0) begin
            fails++;
            $display("FAIL pwm_negative duty=%0d want 0", $signed(d));
        end
        Kp = '0; Ki = 24'd256; PWMLimit = 24'd5000; IntegralLimit = 24'd0;
        run1(1000, 2'd1, d, ok);
        tests++;
        if (!ok || d !== 24'd0) begin
            fails++;
            $display("FAIL int_zero duty=%0d want 0", $signed(d));
        end
        Ki = '0; PWMLimit = 24'h7fffff;
        run1(-8388608, 2'd2, d, ok);
        e = 24'h800001;
        tests++;
        if (!ok || d !== e) begin
            fails++;
            $display("FAIL full_scale duty=%0d want -8388607", $signed(d));
        end
        Kp = 24'd256; state = 24'h800001;
        setpoint = 24'h7fffff; mode = 2'd1; update = 1'b1;
        @(posedge CLK); #1;
        update = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        e = 24'h7fffff;
        tests++;
        if (duty_valid !== 1'b1 || duty !== e) begin
            fails++;
            $display("FAIL err_sat duty=%0d dv=%0b want 8388607/1", $signed(duty), duty_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] e;
        logic seen;
        int exp[3] = '{10, 20, 30};
        defaults();
        Kp = 24'd256;
        for (int i = 0; i < 3; i++) begin
            setpoint = 24'(exp[i]); update = 1'b1;
            @(posedge CLK); #1;
        end
        update = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e = 24'(exp[k]);
            tests++;
            if (duty_valid !== 1'b1 || duty !== e) begin
                fails++;
                $display("FAIL b2b[%0d] duty=%0d dv=%0b want %0d/1", k, $signed(duty), duty_valid, exp[k]);
            end
            @(posedge CLK); #1;
        end
        tests++;
        if (duty_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end dv=%0b want 0", duty_valid);
        end
        setpoint = 24'd500; update = 1'b1;
        @(posedge CLK); #1;
        setpoint = 24'd600;
        @(posedge CLK); #1;
        update = 1'b0; reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
            seen = seen | duty_valid;
        end
        tests++;
        if (seen !== 1'b0 || duty !== 24'd0) begin
            fails++;
            $display("FAIL flush dv_seen=%0b duty=%0d want 0/0", seen, $signed(duty));
        end
    endtask

    initial begin
        test_reset();
        test_p_path();
        test_integral();
        test_derivative();
        test_deadband();
        test_modes();
        test_limits();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pid_motor_control.md
Name: pid_motor_control

Overview:
Parametrised PID motor controller, the successor to the fixed 24-bit controller. Adds configurable width, fixed-point gains, a derivative term, deadband, anti-windup clamping, an update strobe and an operating mode select. It sits between the encoder/state path and the PWM generator; its `duty` output feeds the PWM compare value.

Parameters:
- WIDTH, 24, width of setpoint, state, gains, limits and duty (signed two's complement).
- FRAC_BITS, 8, fractional bits of Kp/Ki/Kd; the gain sum is arithmetically shifted right by FRAC_BITS.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- update  in  1  one-cycle strobe; starts one control iteration.
- mode  in  2  0=off, 1=PID, 2=direct, 3=off.
- setpoint  in  WIDTH  signed target; in direct mode, the raw duty request.
- state  in  WIDTH  signed measured value.
- Kp, Ki, Kd  in  WIDTH  signed gains, Q(WIDTH-FRAC_BITS).FRAC_BITS.
- PWMLimit  in  WIDTH  output magnitude limit; a negative value is treated as 0.
- IntegralLimit  in  WIDTH  integral magnitude limit; a negative value is treated as 0.
- deadband  in  WIDTH  error magnitude treated as zero; a negative value is treated as 0.
- duty  out  WIDTH  signed, saturated drive value.
- duty_valid  out  1  one-cycle pulse when `duty` updates.

Behaviour:
- Reset (synchronous, active-high):
  - duty=0, duty_valid=0.
  - integral=0, err_prev=0, pipeline valids=0.
  - Reset overrides an `update` in the same cycle and aborts in-flight iterations; no duty_valid follows.
- Pipeline: 3 stages. `update` at cycle N gives duty/duty_valid at N+3. An update may be accepted every cycle. Inputs are sampled only in the `update` cycle.
- Stage 1, on update:
  - raw = setpoint - state, computed in WIDTH+1 bits and saturated to WIDTH.
  - err = 0 if |raw| <= deadband, else raw.
  - integral_next = clamp(integral + err, ±IntegralLimit), computed in WIDTH+1 bits before the clamp.
  - deriv = err - err_prev, saturated to WIDTH.
  - Register: integral <= integral_next; err_prev <= err.
- Stage 2: pterm = Kp*err, iterm = Ki*integral_next, dterm = Kd*deriv, each 2*WIDTH bits signed.
- Stage 3:
  - sum = pterm + iterm + dterm in 2*WIDTH+2 bits.
  - sum >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
  - Clamp to ±PWMLimit, then drive duty.
- mode 0/3 (off):
  - Iterations still run; duty=0 and duty_valid pulses at N+3.
  - integral held at 0; err_prev <= err so there is no derivative kick on entry to PID.
- mode 2 (direct): duty = clamp(setpoint, ±PWMLimit) at N+3; integral held at 0; err_prev tracked as in off mode.
- mode 1 (PID): as in stages 1-3 above.
  - Mode is sampled at the update cycle and travels with the iteration through the pipeline.
  - A mode change takes effect on the next update.
- Between update strobes, duty holds its last value and integral/err_prev do not change.
- Limits of 0 force duty=0 (PWMLimit) and integral=0 (IntegralLimit).
- The full-scale negative value -2^(WIDTH-1) is never output; the clamp is symmetric at ±(2^(WIDTH-1)-1) at most.

Test Plan:
Defaults for all scenarios: WIDTH=24, FRAC_BITS=8, PWMLimit=5000, IntegralLimit=250, deadband=0, gains 0 unless stated.
- Reset then idle -> duty=0, duty_valid=0. Assert reset together with update -> no duty_valid 3 cycles later.
- P path: mode=1, Kp=256, setpoint=1000, state=0, single update -> duty=1000 with duty_valid exactly 3 cycles later. Repeat with Kp=2560 -> duty=5000 (clamped). Repeat with setpoint=-1000 -> duty=-5000.
- Integral anti-windup: Ki=256, err=100, 4 updates -> duty 100, 200, 250, 250. Then err=-100 -> duty 150.
- Derivative: Kd=256, err step 0->100 over successive updates -> duty 0, 100, 0. Switch from mode=0 to mode=1 with err=100 -> no kick, duty=0 on the first PID update.
- Deadband: deadband=50, Kp=256, Ki=256, err=40 -> duty=0, integral stays 0. err=60 -> duty=60+60=120.
- Direct/off: mode=2, setpoint=-7000 -> duty=-5000. mode=0 -> duty=0 and integral cleared.
- Back-to-back: updates on consecutive cycles -> consecutive duty_valid pulses in order. Reset mid-pipeline -> all flushed, duty=0.
